// File: rtl/tcp_flow_ptr_table_mp.sv
// tcp_flow_ptr_table_mp: per-flow pointer table, one SET/ADD write port, NUM_RD_PORTS round-robin read ports
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   init_done                         table swept to INIT_VAL, accepting requests
//   wr_req_val/addr/data/add/rdy      write (add=1: mem[addr] += data, add=0: mem[addr] = data)
//   rd_req_val/addr/rdy               per-port read request, port i addr at [i*FLOWID_W +: FLOWID_W]
//   rd_resp_val/data/rdy              per-port registered response, held until consumed
module tcp_flow_ptr_table_mp #(
    parameter int FLOWID_W = 6,
    parameter int DATA_W = 17,
    parameter int NUM_RD_PORTS = 2,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    output logic                             init_done,
    input  logic                             wr_req_val,
    input  logic [FLOWID_W-1:0]              wr_req_addr,
    input  logic [DATA_W-1:0]                wr_req_data,
    input  logic                             wr_req_add,
    output logic                             wr_req_rdy,
    input  logic [NUM_RD_PORTS-1:0]          rd_req_val,
    input  logic [NUM_RD_PORTS*FLOWID_W-1:0] rd_req_addr,
    output logic [NUM_RD_PORTS-1:0]          rd_req_rdy,
    output logic [NUM_RD_PORTS-1:0]          rd_resp_val,
    output logic [NUM_RD_PORTS*DATA_W-1:0]   rd_resp_data,
    input  logic [NUM_RD_PORTS-1:0]          rd_resp_rdy
);
    localparam int DEPTH = 2**FLOWID_W;
    localparam int PW = NUM_RD_PORTS > 1 ? $clog2(NUM_RD_PORTS) : 1;
    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_n;
    logic [FLOWID_W-1:0] sweep_addr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic s1_val;
    logic [FLOWID_W-1:0] s1_addr, rd_addr;
    logic [DATA_W-1:0] s1_data, wr_old, wr_new, rd_data;
    logic [PW-1:0] rr_ptr, rr_n, win;
    logic [NUM_RD_PORTS-1:0] cand, gnt;
    logic run;
    always_comb begin
        state_n = state;
        if (state == INIT && &sweep_addr) state_n = RUN;
        run = state == RUN;
        init_done = run;
        wr_req_rdy = run;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            sweep_addr <= '0;
        end else begin
            state <= state_n;
            if (!run) sweep_addr <= sweep_addr + 1'b1;
        end
    end
    // S1 holds the value being written this cycle; both the write S0 and the read
    // path forward it so back-to-back updates and reads see the latest value.
    always_comb begin
        wr_old = (s1_val && s1_addr == wr_req_addr) ? s1_data : mem[wr_req_addr];
        wr_new = wr_req_add ? wr_old + wr_req_data : wr_req_data;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_val <= 1'b0;
            s1_addr <= '0;
            s1_data <= '0;
        end else begin
            s1_val <= run & wr_req_val;
            s1_addr <= wr_req_addr;
            s1_data <= wr_new;
        end
    end
    always_ff @(posedge clk) begin
        if (!run) mem[sweep_addr] <= INIT_VAL;
        else if (s1_val) mem[s1_addr] <= s1_data;
    end
    // Ports already holding a response drop out of arbitration, so a stalled
    // consumer never blocks the others.
    always_comb begin
        cand = run ? rd_req_val & ~rd_resp_val : '0;
        gnt = '0;
        win = '0;
        for (int k = 0; k < NUM_RD_PORTS; k++) begin
            int j;
            j = (int'(rr_ptr) + k) % NUM_RD_PORTS;
            if (!(|gnt) && cand[j]) begin
                gnt[j] = 1'b1;
                win = PW'(j);
            end
        end
        rr_n = |gnt ? PW'((int'(win) + 1) % NUM_RD_PORTS) : rr_ptr;
        rd_req_rdy = gnt;
        rd_addr = rd_req_addr[int'(win)*FLOWID_W +: FLOWID_W];
        rd_data = (s1_val && s1_addr == rd_addr) ? s1_data : mem[rd_addr];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            rd_resp_val <= '0;
            rd_resp_data <= '0;
        end else begin
            rr_ptr <= rr_n;
            for (int i = 0; i < NUM_RD_PORTS; i++) begin
                if (gnt[i]) begin
                    rd_resp_val[i] <= 1'b1;
                    rd_resp_data[i*DATA_W +: DATA_W] <= rd_data;
                end else if (rd_resp_rdy[i]) begin
                    rd_resp_val[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_tcp_flow_ptr_table_mp.sv
// tb_tcp_flow_ptr_table_mp: directed self-checking bench for tcp_flow_ptr_table_mp
module tb_tcp_flow_ptr_table_mp;
    localparam int FW = 6;
    localparam int DW = 17;
    localparam int NP = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_done;
    logic wr_req_val = 1'b0;
    logic [FW-1:0] wr_req_addr = '0;
    logic [DW-1:0] wr_req_data = '0;
    logic wr_req_add = 1'b0;
    logic wr_req_rdy;
    logic [NP-1:0] rd_req_val = '0;
    logic [NP*FW-1:0] rd_req_addr = '0;
    logic [NP-1:0] rd_req_rdy;
    logic [NP-1:0] rd_resp_val;
    logic [NP*DW-1:0] rd_resp_data;
    logic [NP-1:0] rd_resp_rdy = '1;
    int n_chk = 0;
    int n_fail = 0;
    int g0;

    tcp_flow_ptr_table_mp #(.FLOWID_W(FW), .DATA_W(DW), .NUM_RD_PORTS(NP), .INIT_VAL('0)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .wr_req_val(wr_req_val), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .wr_req_add(wr_req_add), .wr_req_rdy(wr_req_rdy),
        .rd_req_val(rd_req_val), .rd_req_addr(rd_req_addr), .rd_req_rdy(rd_req_rdy),
        .rd_resp_val(rd_resp_val), .rd_resp_data(rd_resp_data), .rd_resp_rdy(rd_resp_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [FW-1:0] a, input logic [DW-1:0] d, input logic add);
        wr_req_val = 1'b1;
        wr_req_addr = a;
        wr_req_data = d;
        wr_req_add = add;
        step;
        wr_req_val = 1'b0;
    endtask

    task automatic rd(input int p, input logic [FW-1:0] a, input logic [DW-1:0] exp);
        rd_req_val[p] = 1'b1;
        rd_req_addr[p*FW +: FW] = a;
        rd_resp_rdy[p] = 1'b1;
        #1;
        chk("rd_req_rdy", 64'(rd_req_rdy[p]), 64'd1);
        step;
        rd_req_val[p] = 1'b0;
        chk("rd_resp_val", 64'(rd_resp_val[p]), 64'd1);
        chk($sformatf("rd_data p%0d flow%0d", p, a), 64'(rd_resp_data[p*DW +: DW]), 64'(exp));
        step;
        chk("rd_resp_clear", 64'(rd_resp_val[p]), 64'd0);
    endtask

    task automatic wait_init;
        rst_n = 1'b1;
        repeat (63) step;
        chk("init_done_early", 64'(init_done), 64'd0);
        step;
        chk("init_done_64", 64'(init_done), 64'd1);
        chk("wr_req_rdy_run", 64'(wr_req_rdy), 64'd1);
    endtask

    initial begin
        // 1. reset state, init timing, table clear
        rd_req_val = 2'b11;
        wr_req_val = 1'b1;
        step;
        step;
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_wr_rdy", 64'(wr_req_rdy), 64'd0);
        chk("rst_rd_rdy", 64'(rd_req_rdy), 64'd0);
        chk("rst_resp_val", 64'(rd_resp_val), 64'd0);
        chk("rst_resp_data", 64'(rd_resp_data), 64'd0);
        rd_req_val = '0;
        wr_req_val = 1'b0;
        wait_init;
        for (int f = 0; f < 64; f++) rd(0, FW'(f), '0);
        // 2. SET then immediate read through the S1 forward path
        wr(6'd5, 17'h00100, 1'b0);
        rd(0, 6'd5, 17'h00100);
        // 3. ADD chain with wrap, then same-cycle write is invisible to the read
        wr(6'd3, 17'h00002, 1'b0);
        wr(6'd3, 17'h1FFFF, 1'b1);
        wr(6'd3, 17'h1FFFF, 1'b1);
        wr(6'd3, 17'h1FFFF, 1'b1);
        rd(0, 6'd3, 17'h1FFFF);
        wr_req_val = 1'b1;
        wr_req_addr = 6'd3;
        wr_req_data = 17'h00055;
        wr_req_add = 1'b0;
        rd(0, 6'd3, 17'h1FFFF);
        wr_req_val = 1'b0;
        rd(0, 6'd3, 17'h00055);
        // 4. both ports continuous; RR pointer sits at 1 after port0-only traffic
        rd_resp_rdy = 2'b11;
        rd_req_addr = {6'd3, 6'd5};
        rd_req_val = 2'b11;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("rr_grant k%0d", k), 64'(rd_req_rdy), (k % 2 == 0) ? 64'd2 : 64'd1);
            step;
            if (k % 2 == 0) chk("rr_data p1", 64'(rd_resp_data[DW +: DW]), 64'h55);
            else chk("rr_data p0", 64'(rd_resp_data[0 +: DW]), 64'h100);
        end
        rd_req_val = '0;
        step;
        step;
        // 5. port1 stalls its response for 10 cycles
        rd_resp_rdy = 2'b01;
        rd_req_addr = {6'd5, 6'd3};
        rd_req_val = 2'b10;
        step;
        rd_req_val = 2'b11;
        g0 = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 0) begin
                wr_req_val = 1'b1;
                wr_req_addr = 6'd9;
                wr_req_data = 17'h01234;
                wr_req_add = 1'b0;
            end
            #1;
            if (k == 0) chk("wr_rdy_stall", 64'(wr_req_rdy), 64'd1);
            chk("stall_rdy1", 64'(rd_req_rdy[1]), 64'd0);
            chk("stall_val1", 64'(rd_resp_val[1]), 64'd1);
            chk("stall_data1", 64'(rd_resp_data[DW +: DW]), 64'h100);
            if (rd_req_rdy[0]) g0++;
            step;
            wr_req_val = 1'b0;
        end
        chk("stall_port0_grants", 64'(g0), 64'd5);
        rd_req_val = '0;
        rd_resp_rdy = 2'b11;
        step;
        step;
        rd(1, 6'd9, 17'h01234);
        // 6. reset mid ADD burst with a held response
        rd_resp_rdy = 2'b01;
        rd_req_addr = {6'd5, 6'd0};
        rd_req_val = 2'b10;
        wr_req_val = 1'b1;
        wr_req_addr = 6'd7;
        wr_req_data = 17'h00001;
        wr_req_add = 1'b1;
        step;
        rd_req_val = '0;
        step;
        chk("pre_rst_val1", 64'(rd_resp_val[1]), 64'd1);
        rd_req_val = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_init_done", 64'(init_done), 64'd0);
        chk("arst_wr_rdy", 64'(wr_req_rdy), 64'd0);
        chk("arst_rd_rdy", 64'(rd_req_rdy), 64'd0);
        chk("arst_resp_val", 64'(rd_resp_val), 64'd0);
        chk("arst_resp_data", 64'(rd_resp_data), 64'd0);
        rd_req_val = '0;
        wr_req_val = 1'b0;
        rd_resp_rdy = 2'b11;
        step;
        step;
        wait_init;
        rd(0, 6'd3, '0);
        rd(1, 6'd5, '0);
        rd(0, 6'd7, '0);
        rd(1, 6'd9, '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
